// File: rtl/entry_allocator.sv
// rtl/entry_allocator.sv - dual-grant free-entry allocator with fixed or rotating search start
// Tracks a busy vector; grants up to two free entries per cycle, all-or-nothing.
module entry_allocator #(
  parameter int ENTSEL = 2,
  parameter int ENTNUM = 4,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ENTNUM-1:0] release_mask,
  input  logic              flush,
  output logic [ENTSEL-1:0] idx0,
  output logic [ENTSEL-1:0] idx1,
  output logic              en0,
  output logic              en1,
  output logic              stall,
  output logic [ENTNUM-1:0] busy,
  output logic [ENTSEL:0]   free_cnt
);

  localparam int EXTN = 1 << ENTSEL;

  logic [ENTNUM-1:0] busy_q, busy_d;
  logic [ENTSEL-1:0] ptr_q, ptr_d;

  logic [EXTN-1:0]   busy_ext;
  logic [EXTN-1:0]   grant_ext;
  logic [ENTNUM-1:0] grant;
  logic              found0, found1;
  int                start, pos, cnt, nreq, last;

  always_comb begin
    busy_ext               = '1;
    busy_ext[ENTNUM-1:0]   = busy_q;
    start                  = (MODE == 1) ? int'(ptr_q) : 0;
    idx0                   = '0;
    idx1                   = '0;
    found0                 = 1'b0;
    found1                 = 1'b0;
    cnt                    = 0;
    pos                    = 0;
    // Scan wraps at ENTNUM so non-power-of-two depths never touch phantom slots.
    for (int k = 0; k < ENTNUM; k++) begin
      pos = start + k;
      if (pos >= ENTNUM) pos = pos - ENTNUM;
      if (!busy_ext[ENTSEL'(pos)]) begin
        cnt = cnt + 1;
        if (!found0) begin
          idx0   = ENTSEL'(pos);
          found0 = 1'b1;
        end else if (!found1) begin
          idx1   = ENTSEL'(pos);
          found1 = 1'b1;
        end
      end
    end
    free_cnt = (ENTSEL+1)'(cnt);
    en0      = (cnt >= 1);
    en1      = (cnt >= 2);
    nreq     = (req0 ? 1 : 0) + (req1 ? 1 : 0);
    stall    = (nreq > cnt);
  end

  always_comb begin
    grant_ext = '0;
    last      = 0;
    if (!stall && nreq != 0) begin
      grant_ext[idx0] = 1'b1;
      last            = int'(idx0);
      if (nreq == 2) begin
        grant_ext[idx1] = 1'b1;
        last            = int'(idx1);
      end
    end
    grant  = grant_ext[ENTNUM-1:0];
    busy_d = (busy_q | grant) & ~release_mask;
    ptr_d  = ptr_q;
    if (MODE != 1) begin
      ptr_d = '0;
    end else if (grant != '0) begin
      ptr_d = (last + 1 >= ENTNUM) ? '0 : ENTSEL'(last + 1);
    end
    if (flush) begin
      busy_d = '0;
      ptr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      ptr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: doc/entry_allocator.md
ENTRY_ALLOCATOR -- requirements
Module: entry_allocator

Interface
REQ-001 Parameter ENTSEL, default 2, index width; SHALL satisfy ENTNUM <= 2**ENTSEL.
REQ-002 Parameter ENTNUM, default 4, number of tracked entries; SHALL be >= 2, need not be a power of two.
REQ-003 Parameter MODE, default 0; 0 = fixed priority (lowest index first), 1 = rotating start pointer.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 req0  input  1  request for first allocation this cycle.
REQ-007 req1  input  1  request for second allocation this cycle.
REQ-008 release_mask  input  ENTNUM  bit i set = free entry i at the clock edge.
REQ-009 flush  input  1  free all entries and reset the pointer.
REQ-010 idx0  output  ENTSEL  first free entry index from the search start.
REQ-011 idx1  output  ENTSEL  second free entry index from the search start.
REQ-012 en0  output  1  at least one free entry.
REQ-013 en1  output  1  at least two free entries.
REQ-014 stall  output  1  requested count exceeds free count; no allocation this cycle.
REQ-015 busy  output  ENTNUM  current busy vector.
REQ-016 free_cnt  output  ENTSEL+1  number of zero bits in busy.

Function
REQ-017 State SHALL be the busy register (ENTNUM bits) and the pointer ptr (ENTSEL bits, used only when MODE=1; held at 0 when MODE=0).
REQ-018 All outputs SHALL be combinational functions of the registered state and current inputs; zero-latency, no output registers.
REQ-019 Search start SHALL be 0 when MODE=0 and ptr when MODE=1; scan order start, start+1, ..., ENTNUM-1, 0, ..., start-1 (wrap at ENTNUM, not 2**ENTSEL).
REQ-020 idx0 SHALL be the first free index in scan order; idx1 the second; each SHALL be 0 when its en is 0.
REQ-021 Request count n = req0 + req1; stall SHALL be 1 iff n > free_cnt.
REQ-022 When stall=0, grants SHALL be ordered: first granted request takes idx0, second takes idx1 (req1 alone takes idx0).
REQ-023 When stall=1, no busy bit SHALL be set (all-or-nothing); releases and flush still apply.
REQ-024 Next busy = (busy | granted bits) & ~release_mask; release of an already-free bit is a no-op.
REQ-025 Allocation SHALL use the pre-edge busy state: an entry released at edge T is not allocatable in the cycle ending at T.
REQ-026 MODE=1: on any cycle with at least one grant, ptr SHALL become (last granted index + 1) mod ENTNUM; otherwise hold.
REQ-027 flush SHALL override all: next busy = 0, next ptr = 0, regardless of req0/req1/release_mask; stall still computed combinationally.
REQ-028 free_cnt SHALL never exceed ENTNUM; en0 = (free_cnt >= 1), en1 = (free_cnt >= 2).

Reset
REQ-029 Asserting reset SHALL clear busy and ptr asynchronously, without a clock edge, including mid-allocation.
REQ-030 Values while/after reset: busy=0, free_cnt=ENTNUM, en0=1, en1=1, idx0=0, idx1=1, stall=n>ENTNUM (i.e., 0).
REQ-031 Deassertion SHALL be synchronous to clk by the system; first edge after deassertion processes requests normally.

Verification (ENTNUM=4, ENTSEL=2)
REQ-032 Reset -> busy=0000, free_cnt=4, idx0=0, idx1=1, en0=en1=1, stall=0.
REQ-033 MODE=0, req0=req1=1 two cycles -> busy 0011 then 1111, free_cnt=0, en0=0; third cycle req0=1 -> stall=1, busy stays 1111.
REQ-034 MODE=0, busy=1111, req0=1 with release_mask=0100 -> stall=1; next cycle busy=1011, idx0=2, en1=0; busy=1110, req0=req1=1 -> stall=1 (free_cnt=1), busy unchanged.
REQ-035 MODE=1, from reset alloc two -> busy 0011, ptr=2; release 0001 -> idx0=2, idx1=3; alloc two -> busy 1110, ptr=0 (wrap); idx0=0, idx1 invalid, en1=0.
REQ-036 busy=0110, ptr=3, flush=1 with req0=1 and release_mask=0010 -> next busy=0000, ptr=0; reset pulsed mid-cycle with busy=1111 -> busy=0000 before next edge.
REQ-037 ENTNUM=3, ENTSEL=2, MODE=1: ptr=2, busy=100 -> idx0=0, idx1=1 (wrap at 3, never index 3).
